// File: rtl/mp3_tag_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mp3_tag_ctrl
//  Purpose  : Tag-array controller in front of a single-port tag SRAM.
//             After reset, and on every flush request, it sweeps INIT_VALUE
//             into every entry, one write per cycle. Once the sweep is done
//             it serves read and write requests. A 1-bit round-robin pointer
//             decides which side wins when both request in the same cycle.
//  Ports    : clk, rst_n                    - clock, synchronous active-low reset
//             flush_req                     - pulse that starts a clear sweep
//             init_done                     - array is clear, requests are served
//             rd_valid/rd_ready/rd_addr     - read request handshake
//             rd_resp_valid/rd_resp_tag     - read response, one cycle after accept
//             wr_valid/wr_ready/wr_addr/wr_tag - write request handshake
//             sram_csb/sram_web/sram_addr/sram_din/sram_dout - SRAM port
//  Revision : 1.0 - initial release
// ============================================================================
module mp3_tag_ctrl #(
    parameter int                    DATA_WIDTH = 24,
    parameter int                    ADDR_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_req,
    output logic                  init_done,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_resp_valid,
    output logic [DATA_WIDTH-1:0] rd_resp_tag,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_tag,
    output logic                  sram_csb,
    output logic                  sram_web,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_din,
    input  logic [DATA_WIDTH-1:0] sram_dout
);

    localparam logic [0:0] c_ST_CLEAR = 1'b0;
    localparam logic [0:0] c_ST_RUN   = 1'b1;

    // The sweep counter carries one extra bit so that "one past the last
    // address" is a distinct value rather than wrapping back to 0.
    localparam logic [ADDR_WIDTH:0] c_CNT_END = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] c_CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [ADDR_WIDTH:0] r_cnt;
    logic [ADDR_WIDTH:0] w_cnt_nxt;
    logic [ADDR_WIDTH:0] w_cnt_inc;
    logic                r_rr_ptr;
    logic                r_rd_resp_valid;

    logic w_in_run;
    logic w_in_clear;
    logic w_serve;
    logic w_contest;
    logic w_rd_go;
    logic w_wr_go;

    // Every output is gated by rst_n so the SRAM stays idle and no handshake
    // is offered during cycles in which reset is held.
    assign w_in_run   = rst_n && (r_state == c_ST_RUN);
    assign w_in_clear = rst_n && (r_state == c_ST_CLEAR);
    assign w_serve    = w_in_run && !flush_req;
    assign w_contest  = rd_valid && wr_valid;

    // A lone requester always wins. When both request, the pointer decides.
    assign rd_ready = w_serve && (!wr_valid || !r_rr_ptr);
    assign wr_ready = w_serve && (!rd_valid ||  r_rr_ptr);
    assign w_rd_go  = rd_valid && rd_ready;
    assign w_wr_go  = wr_valid && wr_ready;

    assign init_done     = w_in_run;
    assign rd_resp_valid = r_rd_resp_valid && rst_n;
    assign rd_resp_tag   = sram_dout;

    assign w_cnt_inc = r_cnt + c_CNT_ONE;

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_ST_CLEAR: begin
                // flush_req is not looked at here: a sweep neither restarts
                // nor extends.
                if (w_cnt_inc == c_CNT_END) begin
                    w_state_nxt = c_ST_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                if (flush_req) begin
                    w_state_nxt = c_ST_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
        endcase
    end

    // SRAM drive. The SRAM gets one access per cycle, chosen by the grant.
    always_comb begin
        sram_csb  = 1'b1;
        sram_web  = 1'b1;
        sram_addr = '0;
        sram_din  = '0;
        if (w_in_clear) begin
            sram_csb  = 1'b0;
            sram_web  = 1'b0;
            sram_addr = r_cnt[ADDR_WIDTH-1:0];
            sram_din  = INIT_VALUE;
        end else if (w_rd_go) begin
            sram_csb  = 1'b0;
            sram_addr = rd_addr;
        end else if (w_wr_go) begin
            sram_csb  = 1'b0;
            sram_web  = 1'b0;
            sram_addr = wr_addr;
            sram_din  = wr_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= c_ST_CLEAR;
            r_cnt           <= '0;
            r_rr_ptr        <= 1'b0;
            r_rd_resp_valid <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            // The pointer only moves after a grant that was actually
            // contested, so an uncontested port never loses its turn.
            r_rr_ptr        <= r_rr_ptr ^ (w_serve && w_contest);
            // The response is registered, so a flush in the cycle after a
            // read accept does not cancel it.
            r_rd_resp_valid <= w_rd_go;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mp3_tag_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mp3_tag_ctrl
//  Purpose  : Directed self-checking bench for mp3_tag_ctrl, with a
//             behavioural tag SRAM. The SRAM writes on negedge and reads
//             on posedge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mp3_tag_ctrl;

    localparam int c_DW = 24;
    localparam int c_AW = 4;

    logic              clk;
    logic              rst_n;
    logic              flush_req;
    logic              init_done;
    logic              rd_valid;
    logic              rd_ready;
    logic [c_AW-1:0]   rd_addr;
    logic              rd_resp_valid;
    logic [c_DW-1:0]   rd_resp_tag;
    logic              wr_valid;
    logic              wr_ready;
    logic [c_AW-1:0]   wr_addr;
    logic [c_DW-1:0]   wr_tag;
    logic              sram_csb;
    logic              sram_web;
    logic [c_AW-1:0]   sram_addr;
    logic [c_DW-1:0]   sram_din;
    logic [c_DW-1:0]   sram_dout;

    int n_checks;
    int n_errors;

    mp3_tag_ctrl #(
        .DATA_WIDTH(c_DW),
        .ADDR_WIDTH(c_AW),
        .INIT_VALUE('0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_req    (flush_req),
        .init_done    (init_done),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_addr      (rd_addr),
        .rd_resp_valid(rd_resp_valid),
        .rd_resp_tag  (rd_resp_tag),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_tag       (wr_tag),
        .sram_csb     (sram_csb),
        .sram_web     (sram_web),
        .sram_addr    (sram_addr),
        .sram_din     (sram_din),
        .sram_dout    (sram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural tag SRAM, preloaded with non-zero garbage so that the
    // clear sweep has a visible effect.
    logic [c_DW-1:0] mem [16];
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 24'hDEAD00 + 24'(i);
        sram_dout = '0;
    end
    always @(negedge clk) if (!sram_csb && !sram_web) mem[sram_addr] <= sram_din;
    always @(posedge clk) if (!sram_csb &&  sram_web) sram_dout <= mem[sram_addr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packed view of {csb, web, addr, din, init_done, rd_ready, wr_ready}.
    function automatic logic [63:0] port_vec();
        return 64'({sram_csb, sram_web, sram_addr, sram_din, init_done, rd_ready, wr_ready});
    endfunction

    function automatic logic [63:0] exp_vec(input logic csb, input logic web,
                                            input logic [c_AW-1:0] a, input logic [c_DW-1:0] d,
                                            input logic idn, input logic rr, input logic wr);
        return 64'({csb, web, a, d, idn, rr, wr});
    endfunction

    // Call this already inside the first sweep cycle (address 0). It checks
    // 16 writes of 0 in ascending address order, pulses flush_req during the
    // sweep at index flush_at, and returns in the first RUN cycle.
    task automatic do_sweep(input string tag, input int flush_at);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) tick();
            flush_req = (i == flush_at);
            #2;
            chk({tag, "_sweep"}, port_vec(), exp_vec(1'b0, 1'b0, 4'(i), '0, 1'b0, 1'b0, 1'b0));
        end
        tick();
        flush_req = 1'b0;
        #2;
        chk({tag, "_init_done"}, 64'(init_done), 64'd1);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        flush_req = 1'b0;
        rd_valid  = 1'b1;
        wr_valid  = 1'b1;
        rd_addr   = '0;
        wr_addr   = '0;
        wr_tag    = 24'h5A5A5A;

        // Outputs while reset is held, with both requesters active.
        tick(); tick();
        #2;
        chk("reset_outputs", port_vec(), exp_vec(1'b1, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0));
        chk("reset_resp", 64'(rd_resp_valid), 64'd0);
        rd_valid = 1'b0;
        wr_valid = 1'b0;

        // Release, then the sweep. init_done rises on cycle 17.
        tick();
        rst_n = 1'b1;
        do_sweep("por", -1);

        // Back-to-back reads of every address all return the cleared value.
        for (int j = 0; j < 16; j++) begin
            tick();
            rd_valid = 1'b1;
            rd_addr  = 4'(j);
            #2;
            chk("rdall_grant", port_vec(), exp_vec(1'b0, 1'b1, 4'(j), '0, 1'b1, 1'b1, 1'b0));
            chk("rdall_resp_valid", 64'(rd_resp_valid), 64'(j > 0));
            if (j > 0) chk("rdall_resp_tag", 64'(rd_resp_tag), 64'd0);
        end
        tick();
        rd_valid = 1'b0;
        #2;
        chk("rdall_last_valid", 64'(rd_resp_valid), 64'd1);
        chk("rdall_last_tag", 64'(rd_resp_tag), 64'd0);

        // Write addr 5, then read it back on the very next cycle.
        tick();
        wr_valid = 1'b1; wr_addr = 4'd5; wr_tag = 24'hABCDEF;
        #2;
        chk("wr5_grant", port_vec(), exp_vec(1'b0, 1'b0, 4'd5, 24'hABCDEF, 1'b1, 1'b1, 1'b1));
        chk("wr5_no_resp", 64'(rd_resp_valid), 64'd0);
        tick();
        wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 4'd5;
        #2;
        chk("rd5_ready", 64'({rd_ready, sram_csb, sram_web, sram_addr}), 64'({1'b1, 1'b0, 1'b1, 4'd5}));
        tick();
        rd_valid = 1'b0;
        #2;
        chk("rd5_resp_valid", 64'(rd_resp_valid), 64'd1);
        chk("rd5_resp_tag", 64'(rd_resp_tag), 64'hABCDEF);

        // Contention: both valid for 4 cycles -> R, W, R, W.
        tick();
        rd_valid = 1'b1; rd_addr = 4'd3;
        wr_valid = 1'b1; wr_addr = 4'd7; wr_tag = 24'h111111;
        #2;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                tick();
                #2;
            end
            chk("rr_grant", 64'({rd_ready, wr_ready, sram_web}),
                64'({(k % 2) == 0, (k % 2) == 1, (k % 2) == 0}));
            chk("rr_resp_valid", 64'(rd_resp_valid), 64'((k % 2) == 1));
            if ((k % 2) == 1) chk("rr_resp_tag", 64'(rd_resp_tag), 64'd0);
        end
        tick();
        rd_valid = 1'b0; wr_valid = 1'b0;
        #2;
        chk("rr_tail_no_resp", 64'(rd_resp_valid), 64'd0);

        // A read is accepted, then a flush arrives with rd_valid still high.
        tick();
        rd_valid = 1'b1; rd_addr = 4'd5;
        #2;
        chk("fl_rd_accept", 64'(rd_ready), 64'd1);
        tick();
        flush_req = 1'b1;
        #2;
        chk("fl_cycle_ports", port_vec(), exp_vec(1'b1, 1'b1, '0, '0, 1'b1, 1'b0, 1'b0));
        chk("fl_resp_kept", 64'({rd_resp_valid, rd_resp_tag}), 64'({1'b1, 24'hABCDEF}));
        tick();
        flush_req = 1'b0;
        do_sweep("flush", 4);
        // The first RUN cycle accepts the still-pending read. The data is now cleared.
        chk("fl_run_rd_ready", 64'(rd_ready), 64'd1);
        tick();
        rd_valid = 1'b0;
        #2;
        chk("fl_rd5_cleared", 64'({rd_resp_valid, rd_resp_tag}), 64'({1'b1, 24'h000000}));

        // Reset asserted in the cycle after a read accept suppresses the response.
        tick();
        rd_valid = 1'b1; rd_addr = 4'd2;
        #2;
        chk("mr_accept", 64'(rd_ready), 64'd1);
        tick();
        rd_valid = 1'b0; rst_n = 1'b0;
        #2;
        chk("mr_resp_suppressed", 64'(rd_resp_valid), 64'd0);
        chk("mr_sram_idle", 64'({sram_csb, sram_web}), 64'd3);
        tick();
        rst_n = 1'b1;
        #2;
        chk("mr_resp_cleared", 64'(rd_resp_valid), 64'd0);

        // Sweep up to address 9, pulse reset for one cycle, then restart at 0.
        for (int i = 0; i < 9; i++) begin
            if (i > 0) begin
                tick();
                #2;
            end
            chk("ms_sweep", 64'({sram_csb, sram_web, sram_addr}), 64'({1'b0, 1'b0, 4'(i)}));
        end
        tick();
        rst_n = 1'b0;
        #2;
        chk("ms_reset_ports", port_vec(), exp_vec(1'b1, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0));
        tick();
        rst_n = 1'b1;
        do_sweep("restart", -1);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
